// File: rtl/mips_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mips_mem_responder
// Brief   : Instruction/data memory responder with an in-order store buffer
//           and youngest-match load forwarding.
// Revision: 1.0 - initial release
// ============================================================================
module mips_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [31:0]                 inst_addr,
  output logic [31:0]                 inst,
  input  logic [31:0]                 data_addr,
  input  logic [31:0]                 data_wdata,
  input  logic                        data_wr,
  output logic [31:0]                 data_rdata,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty,
  output logic                        misalign
);

  localparam int               PW     = $clog2(SB_DEPTH);
  localparam int               CW     = PW + 1;
  localparam int               DEPTH  = 2 ** ADDR_W;
  localparam logic [CW-1:0]    FULL_C = CW'(SB_DEPTH);

  logic [31:0]       mem_q     [DEPTH];
  logic [ADDR_W-1:0] sb_idx_q  [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];

  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                misalign_q, misalign_d;

  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic              aligned;
  logic              enq;
  logic              drain;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [PW-1:0]     slot;
  logic              unused_addr_bits;

  assign inst_idx         = inst_addr[ADDR_W+1:2];
  assign data_idx         = data_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0], data_addr[31:ADDR_W+2]};

  assign aligned = (data_addr[1:0] == 2'b00);
  assign enq     = data_wr && aligned;
  // Draining is held off while the core stores, unless the buffer is full.
  assign drain   = (count_q != '0) && (!data_wr || (count_q == FULL_C));

  always_comb begin
    head_d     = drain ? head_q + PW'(1) : head_q;
    tail_d     = enq   ? tail_q + PW'(1) : tail_q;
    count_d    = count_q + CW'(enq) - CW'(drain);
    misalign_d = misalign_q || (data_wr && !aligned);
    valid_d    = valid_q;
    if (drain) valid_d[head_q] = 1'b0;
    if (enq)   valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      valid_q    <= valid_d;
    end
  end

  // Payload storage and the array itself are intentionally not reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_idx_q[tail_q]  <= data_idx;
      sb_data_q[tail_q] <= data_wdata;
    end
    if (drain) begin
      mem_q[sb_idx_q[head_q]] <= sb_data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot = head_q + PW'(k);
      if ((CW'(k) < count_q) && valid_q[slot] && (sb_idx_q[slot] == data_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[slot];
      end
    end
  end

  assign inst       = mem_q[inst_idx];
  assign data_rdata = fwd_hit ? fwd_data : mem_q[data_idx];
  assign sb_count   = count_q;
  assign sb_empty   = (count_q == '0);
  assign misalign   = misalign_q;

endmodule
`default_nettype wire
